// File: rtl/fu_issue_fifo.sv
// Per-FU issue queue between the RS issue stage and one functional-unit class.
// Accepts up to three matching packets per cycle and presents them head-first to the FU.
module fu_issue_fifo #(
    parameter int unsigned  DEPTH   = 8,
    parameter logic [1:0]   FU_TYPE = 2'd0,  // ALU_1=0, LS_1=1, MULT_1=2, BRANCH=3
    localparam int unsigned PKT_W   = 72,
    localparam int unsigned CNT_W   = $clog2(DEPTH + 1)
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic [2:0][PKT_W-1:0] issue_insts,
    input  logic                  squash,
    input  logic                  fu_ready,
    output logic [PKT_W-1:0]      fu_packet,
    output logic                  fifo_stall,
    output logic [CNT_W-1:0]      count,
    output logic                  overflow_err
);

    localparam int unsigned IDX_W = $clog2(DEPTH);

    typedef struct packed {
        logic        valid;
        logic [1:0]  fu_sel;
        logic [31:0] pc;
        logic [31:0] inst;
        logic [4:0]  dest_tag;
    } rs_s_packet_t;

    rs_s_packet_t     mem_q [DEPTH];
    logic [DEPTH-1:0] vld_q, vld_d;
    logic [IDX_W-1:0] head_q, head_d, tail_q, tail_d;
    logic [CNT_W-1:0] count_q, count_d, free;

    logic [2:0]       wr_en;
    logic [IDX_W-1:0] wr_idx [3];
    rs_s_packet_t     wr_pkt [3];
    rs_s_packet_t     slot, head_pkt;
    logic [1:0]       n_stored;
    logic             dropped, pop;

    // Index arithmetic that wraps correctly for non-power-of-two depths.
    function automatic logic [IDX_W-1:0] wrap_add(input logic [IDX_W-1:0] base,
                                                  input logic [1:0] off);
        logic [IDX_W:0] sum;
        sum = {1'b0, base} + {{(IDX_W-1){1'b0}}, off};
        if (sum >= (IDX_W+1)'(DEPTH)) begin
            sum = sum - (IDX_W+1)'(DEPTH);
        end
        return sum[IDX_W-1:0];
    endfunction

    always_comb begin
        free     = CNT_W'(DEPTH) - count_q;
        pop      = fu_ready && (count_q != '0) && !squash;
        n_stored = '0;
        dropped  = 1'b0;
        wr_en    = '0;
        slot     = '0;
        for (int k = 0; k < 3; k++) begin
            wr_idx[k] = '0;
            wr_pkt[k] = '0;
        end
        // Slot 2 has RS priority; room is judged before this cycle's pop.
        for (int s = 2; s >= 0; s--) begin
            slot = issue_insts[s];
            if (slot.valid && (slot.fu_sel == FU_TYPE)) begin
                if (CNT_W'(n_stored) < free) begin
                    wr_en[n_stored]  = !squash;
                    wr_idx[n_stored] = wrap_add(tail_q, n_stored);
                    wr_pkt[n_stored] = slot;
                    n_stored         = n_stored + 2'd1;
                end else begin
                    dropped = 1'b1;
                end
            end
        end
    end

    always_comb begin
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        vld_d   = vld_q;
        if (squash) begin
            head_d  = '0;
            tail_d  = '0;
            count_d = '0;
            vld_d   = '0;
        end else begin
            if (pop) begin
                head_d        = wrap_add(head_q, 2'd1);
                vld_d[head_q] = 1'b0;
            end
            for (int k = 0; k < 3; k++) begin
                if (wr_en[k]) begin
                    vld_d[wr_idx[k]] = 1'b1;
                end
            end
            tail_d  = wrap_add(tail_q, n_stored);
            count_d = count_q + CNT_W'(n_stored) - CNT_W'(pop);
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
            vld_q   <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
            vld_q   <= vld_d;
        end
    end

    // Payload needs no reset; only the valid bits carry state meaning.
    always_ff @(posedge clock) begin
        for (int k = 0; k < 3; k++) begin
            if (wr_en[k]) begin
                mem_q[wr_idx[k]] <= wr_pkt[k];
            end
        end
    end

    always_comb begin
        head_pkt = '0;
        if ((count_q != '0) && !squash) begin
            head_pkt       = mem_q[head_q];
            head_pkt.valid = vld_q[head_q];
        end
        fu_packet = head_pkt;
    end

    assign count        = count_q;
    assign fifo_stall   = free < CNT_W'(3);
    assign overflow_err = dropped && !squash;

endmodule

// File: tb/tb_fu_issue_fifo.sv
// Bench for fu_issue_fifo: directed corner cases plus randomized traffic checked against a
// queue-based reference model; expectations are queued at issue and consumed by a monitor.
module tb_fu_issue_fifo;

    localparam int unsigned DEPTH = 8;
    localparam logic [1:0] ALU = 2'd0, LS = 2'd1, MULT = 2'd2, BR = 2'd3;

    typedef struct packed {
        logic        valid;
        logic [1:0]  fu_sel;
        logic [31:0] pc;
        logic [31:0] inst;
        logic [4:0]  dest_tag;
    } rs_s_packet_t;

    typedef struct {
        int unsigned  count;
        logic         stall;
        logic         ovf;
        rs_s_packet_t head;
    } exp_t;

    logic               clock = 1'b0;
    logic               reset;
    rs_s_packet_t [2:0] issue_insts;
    logic               squash;
    logic               fu_ready;
    rs_s_packet_t       fu_packet;
    logic               fifo_stall;
    logic [3:0]         count;
    logic               overflow_err;

    exp_t         exp_q [$];
    rs_s_packet_t model_q [$];
    rs_s_packet_t sb_q [$];
    exp_t         mon_e;
    rs_s_packet_t idle_p;
    int           n_checks = 0;
    int           n_pass = 0;

    fu_issue_fifo #(.DEPTH(DEPTH), .FU_TYPE(ALU)) dut (
        .clock        (clock),
        .reset        (reset),
        .issue_insts  (issue_insts),
        .squash       (squash),
        .fu_ready     (fu_ready),
        .fu_packet    (fu_packet),
        .fifo_stall   (fifo_stall),
        .count        (count),
        .overflow_err (overflow_err)
    );

    always #5 clock = ~clock;

    task automatic check(input string name, input logic [71:0] act, input logic [71:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h, expected %h", name, act, exp);
    endtask

    function automatic rs_s_packet_t mk(input logic [1:0] sel, input logic [31:0] pc);
        rs_s_packet_t p;
        p.valid    = 1'b1;
        p.fu_sel   = sel;
        p.pc       = pc;
        p.inst     = pc ^ 32'h1357_9bdf;
        p.dest_tag = pc[6:2];
        return p;
    endfunction

    function automatic rs_s_packet_t rnd_pkt(input int alu_pct);
        rs_s_packet_t p;
        p.valid    = ($urandom_range(0, 99) < 80);
        p.fu_sel   = ($urandom_range(0, 99) < alu_pct) ? ALU : 2'($urandom_range(1, 3));
        p.pc       = $urandom;
        p.inst     = $urandom;
        p.dest_tag = 5'($urandom);
        return p;
    endfunction

    // Apply one cycle of stimulus and derive its expected outcome from the queue model.
    task automatic drive_cycle(input rs_s_packet_t s2, input rs_s_packet_t s1,
                               input rs_s_packet_t s0, input logic sq, input logic rdy);
        exp_t e;
        int   cnt, free, stored;
        logic ovf;
        @(posedge clock);
        #1;
        issue_insts[2] = s2;
        issue_insts[1] = s1;
        issue_insts[0] = s0;
        squash         = sq;
        fu_ready       = rdy;
        cnt     = model_q.size();
        free    = DEPTH - cnt;
        e.count = cnt;
        e.stall = (free < 3);
        e.head  = '0;
        if (cnt != 0 && !sq) e.head = model_q[0];
        ovf = 1'b0;
        if (sq) begin
            model_q.delete();
            sb_q.delete();
        end else begin
            stored = 0;
            for (int i = 2; i >= 0; i--) begin
                rs_s_packet_t p = issue_insts[i];
                if (p.valid && p.fu_sel == ALU) begin
                    if (stored < free) begin
                        model_q.push_back(p);
                        sb_q.push_back(p);
                        stored++;
                    end else begin
                        ovf = 1'b1;
                    end
                end
            end
            if (rdy && cnt != 0) void'(model_q.pop_front());
        end
        e.ovf = ovf;
        exp_q.push_back(e);
    endtask

    always @(negedge clock) begin
        if (exp_q.size() != 0) begin
            mon_e = exp_q.pop_front();
            check("count", 72'(count), 72'(mon_e.count));
            check("fifo_stall", 72'(fifo_stall), 72'(mon_e.stall));
            check("overflow_err", 72'(overflow_err), 72'(mon_e.ovf));
            check("fu_packet", fu_packet, mon_e.head);
            if (fu_packet.valid && fu_ready) begin
                if (sb_q.size() == 0) begin
                    n_checks++;
                    $display("FAIL pop_order: got %h, expected no packet", fu_packet);
                end else begin
                    check("pop_order", fu_packet, sb_q.pop_front());
                end
            end
        end
    end

    initial begin
        idle_p      = '0;
        reset       = 1'b0;
        issue_insts = '0;
        squash      = 1'b0;
        fu_ready    = 1'b0;
        #12;
        check("reset_count", 72'(count), 72'd0);
        check("reset_fu_packet", fu_packet, 72'd0);
        check("reset_stall", 72'(fifo_stall), 72'd0);
        check("reset_overflow", 72'(overflow_err), 72'd0);
        @(negedge clock);
        reset = 1'b1;

        // Mixed FU selections, priority order, then pop through.
        drive_cycle(mk(ALU, 32'h10), mk(MULT, 32'h14), mk(ALU, 32'h18), 1'b0, 1'b0);
        drive_cycle(idle_p, idle_p, idle_p, 1'b0, 1'b0);
        drive_cycle(idle_p, idle_p, idle_p, 1'b0, 1'b1);
        drive_cycle(idle_p, idle_p, idle_p, 1'b0, 1'b1);
        drive_cycle(idle_p, idle_p, idle_p, 1'b0, 1'b0);

        // Stall threshold around free == 3.
        drive_cycle(mk(ALU, 32'h100), mk(ALU, 32'h104), mk(ALU, 32'h108), 1'b0, 1'b0);
        drive_cycle(mk(ALU, 32'h10c), mk(ALU, 32'h110), mk(ALU, 32'h114), 1'b0, 1'b0);
        drive_cycle(idle_p, idle_p, idle_p, 1'b0, 1'b0);
        drive_cycle(idle_p, idle_p, idle_p, 1'b0, 1'b1);
        drive_cycle(idle_p, idle_p, idle_p, 1'b0, 1'b0);

        // Overflow with a same-cycle pop, then full with pop.
        drive_cycle(mk(ALU, 32'h118), mk(ALU, 32'h11c), idle_p, 1'b0, 1'b0);
        drive_cycle(mk(ALU, 32'h120), mk(ALU, 32'h124), mk(ALU, 32'h128), 1'b0, 1'b1);
        drive_cycle(mk(ALU, 32'h12c), idle_p, mk(LS, 32'h130), 1'b0, 1'b0);
        drive_cycle(mk(ALU, 32'h134), mk(BR, 32'h138), mk(ALU, 32'h13c), 1'b0, 1'b1);
        for (int i = 0; i < 9; i++) drive_cycle(idle_p, idle_p, idle_p, 1'b0, 1'b1);

        // Squash with pending pushes.
        drive_cycle(mk(ALU, 32'h200), mk(ALU, 32'h204), mk(ALU, 32'h208), 1'b0, 1'b0);
        drive_cycle(mk(ALU, 32'h20c), idle_p, mk(ALU, 32'h210), 1'b0, 1'b0);
        drive_cycle(mk(ALU, 32'h214), mk(ALU, 32'h218), idle_p, 1'b1, 1'b1);
        drive_cycle(idle_p, idle_p, idle_p, 1'b0, 1'b0);

        // Random traffic, alternating drain-heavy and fill-heavy phases.
        for (int i = 0; i < 400; i++) begin
            int rdy_pct = ((i / 40) % 2 == 0) ? 85 : 30;
            drive_cycle(rnd_pkt(60), rnd_pkt(60), rnd_pkt(60), ($urandom_range(0, 59) == 0),
                        ($urandom_range(0, 99) < rdy_pct));
        end
        for (int i = 0; i < 10; i++) drive_cycle(idle_p, idle_p, idle_p, 1'b0, 1'b1);

        // Asynchronous reset in the middle of a cycle with four entries held.
        drive_cycle(mk(ALU, 32'h300), mk(ALU, 32'h304), mk(ALU, 32'h308), 1'b0, 1'b0);
        drive_cycle(mk(ALU, 32'h30c), idle_p, idle_p, 1'b0, 1'b0);
        @(posedge clock);
        #1;
        issue_insts = '0;
        @(negedge clock);
        #2;
        check("pre_reset_count", 72'(count), 72'(model_q.size()));
        reset = 1'b0;
        #1;
        check("async_reset_count", 72'(count), 72'd0);
        check("async_reset_fu_packet", fu_packet, 72'd0);
        check("async_reset_stall", 72'(fifo_stall), 72'd0);
        model_q.delete();
        sb_q.delete();
        @(negedge clock);
        reset = 1'b1;
        drive_cycle(mk(ALU, 32'h400), idle_p, mk(MULT, 32'h404), 1'b0, 1'b0);
        drive_cycle(idle_p, idle_p, idle_p, 1'b0, 1'b1);
        drive_cycle(idle_p, idle_p, idle_p, 1'b0, 1'b0);

        @(posedge clock);
        @(negedge clock);
        #1;
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
